// File: rtl/xillybus_user_pkg.sv
// Shared widths and status-LED bit positions for the Xillybus user-side responder.
package xillybus_user_pkg;

  localparam int DW      = 32;
  localparam int FIFO_AW = 4;
  localparam int MEM_AW  = 5;

  localparam int LED_FIFO_NONEMPTY = 0;
  localparam int LED_OVERFLOW      = 1;
  localparam int LED_W_OPEN        = 2;
  localparam int LED_R_OPEN        = 3;

  // Falling edges of the two loopback file opens, plus the flush they imply.
  typedef struct packed {
    logic w_fall;
    logic r_fall;
    logic flush;
  } open_evt_t;

  function automatic open_evt_t open_events(input logic w_prev, input logic w_now,
                                            input logic r_prev, input logic r_now);
    open_evt_t e;
    e.w_fall = w_prev & ~w_now;
    e.r_fall = r_prev & ~r_now;
    e.flush  = ~w_now & ~r_now & (e.w_fall | e.r_fall);
    return e;
  endfunction

endpackage

// File: rtl/xillybus_user_fifo.sv
// Synchronous standard-mode loopback FIFO: registered read data one cycle after rd_en,
// full/empty decoded from the occupancy count, sticky overflow, synchronous flush.
module xillybus_user_fifo
  import xillybus_user_pkg::*;
#(
  parameter int W  = DW,
  parameter int AW = FIFO_AW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         wr_ok
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A read frees a slot in the same cycle, so a write into a full FIFO is legal alongside it.
  assign rd_ok = rd_en & ~flush & ~empty;
  assign wr_ok = wr_en & ~flush & (~full | rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) store[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_dat   <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_dat <= store[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/xillybus_user_responder.sv
// User-side Xillybus endpoint: write_32 -> loopback FIFO -> read_32 with EOF/flush on file
// close, plus a seekable 32x32 register bank behind mem_32.
module xillybus_user_responder
  import xillybus_user_pkg::*;
#(
  parameter int DW_P      = DW,
  parameter int FIFO_AW_P = FIFO_AW,
  parameter int MEM_AW_P  = MEM_AW
) (
  input  logic                bus_clk_w,
  input  logic                trn_reset_n_w,
  input  logic                user_w_write_32_wren_w,
  input  logic [DW_P-1:0]     user_w_write_32_data_w,
  input  logic                user_w_write_32_open_w,
  output logic                user_w_write_32_full_w,
  input  logic                user_r_read_32_rden_w,
  input  logic                user_r_read_32_open_w,
  output logic [DW_P-1:0]     user_r_read_32_data_w,
  output logic                user_r_read_32_empty_w,
  output logic                user_r_read_32_eof_w,
  input  logic [MEM_AW_P-1:0] user_mem_32_addr_w,
  input  logic                user_mem_32_addr_update_w,
  input  logic                user_w_mem_32_wren_w,
  input  logic [DW_P-1:0]     user_w_mem_32_data_w,
  input  logic                user_w_mem_32_open_w,
  output logic                user_w_mem_32_full_w,
  input  logic                user_r_mem_32_rden_w,
  input  logic                user_r_mem_32_open_w,
  output logic [DW_P-1:0]     user_r_mem_32_data_w,
  output logic                user_r_mem_32_empty_w,
  output logic                user_r_mem_32_eof_w,
  output logic [3:0]          status_led_w
);

  localparam int MEM_DEPTH = 1 << MEM_AW_P;

  logic      w_open_q;
  logic      r_open_q;
  open_evt_t evt;
  logic      written;
  logic      eof_pending;
  logic      fifo_overflow;
  logic      fifo_wr_ok;

  assign evt = open_events(w_open_q, user_w_write_32_open_w,
                           r_open_q, user_r_read_32_open_w);

  xillybus_user_fifo #(
    .W  (DW_P),
    .AW (FIFO_AW_P)
  ) u_fifo (
    .clk      (bus_clk_w),
    .rst_n    (trn_reset_n_w),
    .flush    (evt.flush),
    .wr_en    (user_w_write_32_wren_w),
    .wr_dat   (user_w_write_32_data_w),
    .rd_en    (user_r_read_32_rden_w),
    .rd_dat   (user_r_read_32_data_w),
    .full     (user_w_write_32_full_w),
    .empty    (user_r_read_32_empty_w),
    .overflow (fifo_overflow),
    .wr_ok    (fifo_wr_ok)
  );

  // EOF is only meaningful if the writer actually produced data since the last flush.
  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      w_open_q    <= 1'b0;
      r_open_q    <= 1'b0;
      written     <= 1'b0;
      eof_pending <= 1'b0;
    end else begin
      w_open_q <= user_w_write_32_open_w;
      r_open_q <= user_r_read_32_open_w;
      if (evt.flush)       written <= 1'b0;
      else if (fifo_wr_ok) written <= 1'b1;
      if (evt.r_fall)                eof_pending <= 1'b0;
      else if (evt.w_fall && written) eof_pending <= 1'b1;
    end
  end

  assign user_r_read_32_eof_w = eof_pending & user_r_read_32_empty_w;

  assign status_led_w[LED_R_OPEN]        = user_r_read_32_open_w;
  assign status_led_w[LED_W_OPEN]        = user_w_write_32_open_w;
  assign status_led_w[LED_OVERFLOW]      = fifo_overflow;
  assign status_led_w[LED_FIFO_NONEMPTY] = ~user_r_read_32_empty_w;

  logic [DW_P-1:0]     bank [MEM_DEPTH];
  logic [MEM_AW_P-1:0] mem_ptr;
  logic [MEM_AW_P-1:0] mem_addr;
  logic                mem_access;

  // A seek in the same cycle as an access redirects that access to the new address.
  assign mem_addr   = user_mem_32_addr_update_w ? user_mem_32_addr_w : mem_ptr;
  assign mem_access = user_w_mem_32_wren_w | user_r_mem_32_rden_w;

  always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
    if (!trn_reset_n_w) begin
      mem_ptr              <= '0;
      user_r_mem_32_data_w <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) bank[i] <= '0;
    end else begin
      if (user_w_mem_32_wren_w) bank[mem_addr] <= user_w_mem_32_data_w;
      if (user_r_mem_32_rden_w) user_r_mem_32_data_w <= bank[mem_addr];
      if (mem_access)                     mem_ptr <= mem_addr + 1'b1;
      else if (user_mem_32_addr_update_w) mem_ptr <= user_mem_32_addr_w;
    end
  end

  assign user_w_mem_32_full_w  = 1'b0;
  assign user_r_mem_32_empty_w = 1'b0;
  assign user_r_mem_32_eof_w   = 1'b0;

  // The mem stream's open flags carry no function here; the bank persists across opens.
  logic unused_mem_opens;
  assign unused_mem_opens = &{1'b0, user_w_mem_32_open_w, user_r_mem_32_open_w};

endmodule

// File: tb/tb_xillybus_user_responder.sv
// Directed + randomized bench for xillybus_user_responder against a queue/array reference model.
module tb_xillybus_user_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0, w_open = 1'b0, rden = 1'b0, r_open = 1'b0;
  logic [31:0] wdata = '0;
  logic [4:0]  maddr = '0;
  logic        mupd = 1'b0, mwren = 1'b0, mrden = 1'b0, mw_open = 1'b0, mr_open = 1'b0;
  logic [31:0] mdata = '0;

  logic        full, empty, eof, mfull, mempty, meof;
  logic [31:0] rdata, mrdata;
  logic [3:0]  led;

  always #5 clk = ~clk;

  xillybus_user_responder dut (
    .bus_clk_w                 (clk),
    .trn_reset_n_w             (rst_n),
    .user_w_write_32_wren_w    (wren),
    .user_w_write_32_data_w    (wdata),
    .user_w_write_32_open_w    (w_open),
    .user_w_write_32_full_w    (full),
    .user_r_read_32_rden_w     (rden),
    .user_r_read_32_open_w     (r_open),
    .user_r_read_32_data_w     (rdata),
    .user_r_read_32_empty_w    (empty),
    .user_r_read_32_eof_w      (eof),
    .user_mem_32_addr_w        (maddr),
    .user_mem_32_addr_update_w (mupd),
    .user_w_mem_32_wren_w      (mwren),
    .user_w_mem_32_data_w      (mdata),
    .user_w_mem_32_open_w      (mw_open),
    .user_w_mem_32_full_w      (mfull),
    .user_r_mem_32_rden_w      (mrden),
    .user_r_mem_32_open_w      (mr_open),
    .user_r_mem_32_data_w      (mrdata),
    .user_r_mem_32_empty_w     (mempty),
    .user_r_mem_32_eof_w       (meof),
    .status_led_w              (led)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic        m_ovf, m_written, m_eofp, m_prev_w, m_prev_r;
  logic [31:0] m_rdata, m_mrdata;
  logic [31:0] m_bank [32];
  int          m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_written = 0; m_eofp = 0; m_prev_w = 0; m_prev_r = 0;
    m_rdata = '0; m_mrdata = '0; m_ptr = 0;
    for (int i = 0; i < 32; i++) m_bank[i] = '0;
  endtask

  task automatic model_update();
    bit wf, rf, fl, rd_ok;
    int a;
    wf = m_prev_w && !w_open;
    rf = m_prev_r && !r_open;
    fl = !w_open && !r_open && (wf || rf);
    if (wf && m_written) m_eofp = 1;
    if (rf) m_eofp = 0;
    if (fl) begin
      m_q.delete(); m_ovf = 0; m_written = 0;
    end else begin
      rd_ok = rden && (m_q.size() > 0);
      if (rd_ok) m_rdata = m_q.pop_front();
      if (wren) begin
        if (m_q.size() < 16) begin m_q.push_back(wdata); m_written = 1; end
        else m_ovf = 1;
      end
    end
    m_prev_w = w_open;
    m_prev_r = r_open;
    a = mupd ? int'(maddr) : m_ptr;
    if (mrden) m_mrdata = m_bank[a];
    if (mwren) m_bank[a] = mdata;
    if (mwren || mrden) m_ptr = (a + 1) % 32;
    else if (mupd) m_ptr = a;
  endtask

  task automatic check_all();
    chk("full", full, m_q.size() == 16);
    chk("empty", empty, m_q.size() == 0);
    chk("eof", eof, m_eofp && (m_q.size() == 0));
    chk("led", led, {r_open, w_open, m_ovf, m_q.size() != 0});
    chk("rdata", rdata, m_rdata);
    chk("mrdata", mrdata, m_mrdata);
    chk("mem_consts", {mfull, mempty, meof}, 3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle();
    wren = 0; rden = 0; mupd = 0; mwren = 0; mrden = 0;
  endtask

  logic [31:0] exp_t4 [16];

  initial begin
    model_reset();
    #12;
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_eof", eof, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mrdata", mrdata, 0);
    chk("rst_led", led, 4'b0000);
    #5 rst_n = 1'b1;
    w_open = 1; r_open = 1; mw_open = 1; mr_open = 1;
    step();

    // 1: basic loopback order and latency
    for (int i = 1; i <= 5; i++) begin wren = 1; wdata = i; step(); end
    idle();
    for (int i = 1; i <= 5; i++) begin rden = 1; step(); chk("t1_data", rdata, i); end
    idle();
    chk("t1_empty", empty, 1);

    // 2: overflow on 17th write, 16 words read back
    for (int i = 0; i < 17; i++) begin
      wren = 1; wdata = 32'h100 + i; step();
      if (i == 15) chk("t2_full", full, 1);
    end
    idle();
    chk("t2_ovf_led", led[1], 1);
    for (int i = 0; i < 16; i++) begin rden = 1; step(); chk("t2_data", rdata, 32'h100 + i); end
    idle();
    chk("t2_empty", empty, 1);

    // 3: eof after writer closes and reader drains
    for (int i = 0; i < 3; i++) begin wren = 1; wdata = 32'h30 + i; step(); end
    idle(); w_open = 0; step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_eof_pre", eof, 0);
      rden = 1; step();
    end
    idle();
    chk("t3_eof", eof, 1);
    chk("t3_empty", empty, 1);
    r_open = 0; step();
    chk("t3_eof_clr", eof, 0);
    chk("t3_ovf_flushed", led[1], 0);
    w_open = 1; r_open = 1; step();

    // 4: simultaneous write+read at empty and at full
    wren = 1; rden = 1; wdata = 32'h40; step();
    chk("t4_cnt1", {full, empty}, 2'b00);
    rden = 0;
    for (int i = 1; i < 16; i++) begin wdata = 32'h40 + i; step(); end
    chk("t4_full", full, 1);
    rden = 1; wdata = 32'h60; step();
    chk("t4_rd_at_full", rdata, 32'h40);
    chk("t4_still_full", full, 1);
    chk("t4_no_ovf", led[1], 0);
    idle();
    for (int i = 0; i < 15; i++) exp_t4[i] = 32'h41 + i;
    exp_t4[15] = 32'h60;
    for (int i = 0; i < 16; i++) begin rden = 1; step(); chk("t4_order", rdata, exp_t4[i]); end
    idle();

    // 5: mem seek with wrap
    mupd = 1; maddr = 5'd30; mwren = 1; mdata = 32'hA; step();
    mupd = 0; mdata = 32'hB; step();
    mdata = 32'hC; step();
    idle();
    mupd = 1; maddr = 5'd31; step();
    mupd = 0; mrden = 1; step();
    chk("t5_b", mrdata, 32'hB);
    step();
    chk("t5_c", mrdata, 32'hC);
    mupd = 1; maddr = 5'd30; step();
    chk("t5_a", mrdata, 32'hA);
    idle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wren  = ($urandom_range(0, 3) != 0);
      rden  = ($urandom_range(0, 2) != 0);
      wdata = $urandom;
      if ($urandom_range(0, 63) == 0) w_open = ~w_open;
      if ($urandom_range(0, 63) == 0) r_open = ~r_open;
      mupd  = ($urandom_range(0, 7) == 0);
      maddr = 5'($urandom_range(0, 31));
      mwren = $urandom_range(0, 1);
      mrden = $urandom_range(0, 1);
      mdata = $urandom;
      step();
    end
    idle(); w_open = 1; r_open = 1; step();

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) begin
      wren = 1; wdata = 32'h70 + i; mwren = 1; mdata = 32'h80 + i; step();
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_full", full, 0);
    chk("t6_empty", empty, 1);
    chk("t6_eof", eof, 0);
    chk("t6_rdata", rdata, 0);
    chk("t6_mrdata", mrdata, 0);
    chk("t6_led", led, {r_open, w_open, 2'b00});
    idle();
    #2 rst_n = 1'b1;
    step();
    mupd = 1; maddr = 5'd0; mrden = 1; step();
    mupd = 0;
    for (int i = 1; i < 4; i++) begin step(); chk("t6_bank_zero", mrdata, 0); end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
